// File: rtl/mcht_msg_rsp_if.sv
// Request/reply handshake bundle between the Manchester codec and the message responder.
interface mcht_msg_rsp_if #(
  parameter int unsigned pOVF_W = 8
);
  logic              rx_vld;
  logic [15:0]       rx_msg;
  logic              tx_vld;
  logic [15:0]       tx_msg;
  logic              tx_dne;
  logic              busy;
  logic [pOVF_W-1:0] ovf_cnt;
  logic              tmo_err;

  // Codec side: delivers decoded requests, accepts replies.
  modport master (
    output rx_vld, rx_msg, tx_dne,
    input  tx_vld, tx_msg, busy, ovf_cnt, tmo_err
  );

  // Responder side.
  modport slave (
    input  rx_vld, rx_msg, tx_dne,
    output tx_vld, tx_msg, busy, ovf_cnt, tmo_err
  );
endinterface

// File: rtl/mcht_msg_rsp.sv
// Message responder: executes WRITE/READ/PING on a 16x8 register file and returns one reply
// per request through the encoder handshake, with a one-deep request buffer and done timeout.
module mcht_msg_rsp #(
  parameter int unsigned pTURN_CYC = 4,
  parameter int unsigned pDNE_TMO  = 1024,
  parameter int unsigned pOVF_W    = 8
) (
  input logic          clk_25m,
  input logic          rst,
  mcht_msg_rsp_if.slave bus
);

  localparam int unsigned TurnW = (pTURN_CYC > 1) ? $clog2(pTURN_CYC) : 1;
  localparam int unsigned TmoW  = $clog2(pDNE_TMO);
  localparam logic [TurnW-1:0] TurnLast = TurnW'((pTURN_CYC == 0) ? 0 : pTURN_CYC - 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(pDNE_TMO - 1);

  typedef enum logic [2:0] {StIdle, StExec, StTurn, StSend, StWaitDne} state_e;

  state_e            state_q;
  logic [15:0]       cur_q;
  logic [15:0]       pend_q;
  logic              pend_vld_q;
  logic [7:0]        regs_q [16];
  logic              tx_vld_q;
  logic [15:0]       tx_msg_q;
  logic [TurnW-1:0]  turn_cnt_q;
  logic [TmoW-1:0]   tmo_cnt_q;
  logic [pOVF_W-1:0] ovf_cnt_q;
  logic              tmo_err_q;

  logic [3:0] op;
  logic [3:0] addr;
  logic [7:0] data;
  logic       wait_exit;
  logic       rx_busy;

  always_comb begin
    op        = cur_q[15:12];
    addr      = cur_q[11:8];
    data      = cur_q[7:0];
    // WAIT_DNE leaves on done or on timeout, with identical follow-on handling.
    wait_exit = (state_q == StWaitDne) && (bus.tx_dne || (tmo_cnt_q == TmoLast));
    rx_busy   = bus.rx_vld && (state_q != StIdle);
  end

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      tx_vld_q   <= 1'b0;
      tx_msg_q   <= '0;
      turn_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      ovf_cnt_q  <= '0;
      tmo_err_q  <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      tx_vld_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (bus.rx_vld) begin
            cur_q   <= bus.rx_msg;
            state_q <= StExec;
          end
        end
        StExec: begin
          case (op)
            4'h1: begin
              regs_q[addr] <= data;
              tx_msg_q     <= {4'h9, addr, data};
            end
            4'h2:    tx_msg_q <= {4'hA, addr, regs_q[addr]};
            4'h3:    tx_msg_q <= {4'hB, addr, data};
            default: tx_msg_q <= {4'hF, addr, 4'h0, op};
          endcase
          turn_cnt_q <= '0;
          if (pTURN_CYC == 0) begin
            state_q  <= StSend;
            tx_vld_q <= 1'b1;
          end else begin
            state_q <= StTurn;
          end
        end
        StTurn: begin
          if (turn_cnt_q == TurnLast) begin
            state_q  <= StSend;
            tx_vld_q <= 1'b1;
          end else begin
            turn_cnt_q <= turn_cnt_q + TurnW'(1);
          end
        end
        StSend: begin
          state_q   <= StWaitDne;
          tmo_cnt_q <= '0;
        end
        StWaitDne: begin
          if (wait_exit) begin
            if (!bus.tx_dne) tmo_err_q <= 1'b1;
            // Buffered request is older than one arriving right now, so it goes first.
            if (pend_vld_q) begin
              cur_q   <= pend_q;
              state_q <= StExec;
            end else if (bus.rx_vld) begin
              cur_q   <= bus.rx_msg;
              state_q <= StExec;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase

      if (rx_busy) begin
        if (wait_exit) begin
          // Slot is being drained this cycle, so the new request refills it without a drop.
          if (pend_vld_q) pend_q <= bus.rx_msg;
        end else if (!pend_vld_q) begin
          pend_q     <= bus.rx_msg;
          pend_vld_q <= 1'b1;
        end else if (ovf_cnt_q != '1) begin
          ovf_cnt_q <= ovf_cnt_q + pOVF_W'(1);
        end
      end else if (wait_exit && pend_vld_q) begin
        pend_vld_q <= 1'b0;
      end
    end
  end

  assign bus.tx_vld  = tx_vld_q;
  assign bus.tx_msg  = tx_msg_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.ovf_cnt = ovf_cnt_q;
  assign bus.tmo_err = tmo_err_q;

endmodule

// File: tb/tb_mcht_msg_rsp.sv
// Directed bench for mcht_msg_rsp: vector table for single requests plus hand-written
// sequences for buffering, timeout, reset abort and overflow saturation.
module tb_mcht_msg_rsp;

  logic clk = 1'b0;
  logic rst;
  always #20 clk = ~clk;

  logic        rx_vld [2];
  logic [15:0] rx_msg [2];
  logic        tx_dne [2];

  mcht_msg_rsp_if #(.pOVF_W(8)) bus_a ();
  mcht_msg_rsp_if #(.pOVF_W(8)) bus_b ();

  assign bus_a.rx_vld = rx_vld[0];
  assign bus_a.rx_msg = rx_msg[0];
  assign bus_a.tx_dne = tx_dne[0];
  assign bus_b.rx_vld = rx_vld[1];
  assign bus_b.rx_msg = rx_msg[1];
  assign bus_b.tx_dne = tx_dne[1];

  mcht_msg_rsp #(.pTURN_CYC(4), .pDNE_TMO(1024), .pOVF_W(8)) u_dut_a (
    .clk_25m (clk),
    .rst     (rst),
    .bus     (bus_a)
  );

  mcht_msg_rsp #(.pTURN_CYC(4), .pDNE_TMO(16), .pOVF_W(8)) u_dut_b (
    .clk_25m (clk),
    .rst     (rst),
    .bus     (bus_b)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] req;
    logic [15:0] rsp;
  } vec_t;

  vec_t vecs [10];

  function automatic logic tx_vld_of(int d);
    return (d != 0) ? bus_b.tx_vld : bus_a.tx_vld;
  endfunction
  function automatic logic [15:0] tx_msg_of(int d);
    return (d != 0) ? bus_b.tx_msg : bus_a.tx_msg;
  endfunction
  function automatic logic busy_of(int d);
    return (d != 0) ? bus_b.busy : bus_a.busy;
  endfunction
  function automatic logic [7:0] ovf_of(int d);
    return (d != 0) ? bus_b.ovf_cnt : bus_a.ovf_cnt;
  endfunction
  function automatic logic tmo_of(int d);
    return (d != 0) ? bus_b.tmo_err : bus_a.tmo_err;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rx(input int d, input logic [15:0] m);
    rx_vld[d] = 1'b1;
    rx_msg[d] = m;
    tick();
    rx_vld[d] = 1'b0;
  endtask

  task automatic pulse_dne(input int d);
    tx_dne[d] = 1'b1;
    tick();
    tx_dne[d] = 1'b0;
  endtask

  // Returns ticks taken until tx_vld seen, or -1 if the budget expired.
  task automatic wait_tx(input int d, input int budget, output int lat);
    lat = 0;
    while (!tx_vld_of(d) && lat < budget) begin
      tick();
      lat++;
    end
    if (!tx_vld_of(d)) lat = -1;
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n = 0;
    while (busy_of(d) && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic count_tx(input int d, input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      tick();
      if (tx_vld_of(d)) seen++;
    end
  endtask

  // Single request on an idle link, full handshake, latency checked.
  task automatic send_req(input int d, input logic [15:0] m, input logic [15:0] exp,
                          input string name);
    int lat;
    pulse_rx(d, m);
    wait_tx(d, 20, lat);
    check($sformatf("%s lat", name), (lat < 0) ? 32'hFFFF_FFFF : 32'(lat + 1), 32'd6);
    check($sformatf("%s msg", name), {16'h0, tx_msg_of(d)}, {16'h0, exp});
    tick();
    check($sformatf("%s vld1", name), {31'h0, tx_vld_of(d)}, 32'd0);
    tick();
    tick();
    check($sformatf("%s hold", name), {16'h0, tx_msg_of(d)}, {16'h0, exp});
    pulse_dne(d);
    wait_idle(d, 10);
    check($sformatf("%s idle", name), {31'h0, busy_of(d)}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    int n;

    vecs[0] = '{16'h135A, 16'h935A};
    vecs[1] = '{16'h2300, 16'hA35A};
    vecs[2] = '{16'h7211, 16'hF207};
    vecs[3] = '{16'h2200, 16'hA200};
    vecs[4] = '{16'h30AA, 16'hB0AA};
    vecs[5] = '{16'h1FFF, 16'h9FFF};
    vecs[6] = '{16'h2F00, 16'hAFFF};
    vecs[7] = '{16'h0123, 16'hF100};
    vecs[8] = '{16'h1300, 16'h9300};
    vecs[9] = '{16'h2300, 16'hA300};

    for (int d = 0; d < 2; d++) begin
      rx_vld[d] = 1'b0;
      rx_msg[d] = '0;
      tx_dne[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst tx_vld", {31'h0, bus_a.tx_vld}, 32'd0);
    check("rst tx_msg", {16'h0, bus_a.tx_msg}, 32'd0);
    check("rst busy", {31'h0, bus_a.busy}, 32'd0);
    check("rst ovf", {24'h0, bus_a.ovf_cnt}, 32'd0);
    check("rst tmo", {31'h0, bus_a.tmo_err}, 32'd0);

    for (int i = 0; i < 10; i++) send_req(0, vecs[i].req, vecs[i].rsp, $sformatf("vec%0d", i));

    // Three back-to-back requests with done withheld: first sent, second buffered, third lost.
    pulse_rx(0, 16'h3111);
    pulse_rx(0, 16'h3222);
    pulse_rx(0, 16'h3333);
    check("b2b ovf", {24'h0, ovf_of(0)}, 32'd1);
    wait_tx(0, 20, lat);
    check("b2b first", {16'h0, tx_msg_of(0)}, 32'h0000_B111);
    count_tx(0, 50, seen);
    check("b2b held tx", seen, 0);
    check("b2b held msg", {16'h0, tx_msg_of(0)}, 32'h0000_B111);
    check("b2b held busy", {31'h0, busy_of(0)}, 32'd1);
    pulse_dne(0);
    wait_tx(0, 20, lat);
    check("b2b second", (lat < 0) ? 32'hDEAD : {16'h0, tx_msg_of(0)}, 32'h0000_B222);
    tick();
    pulse_dne(0);
    count_tx(0, 30, seen);
    check("b2b third dropped", seen, 0);
    check("b2b idle", {31'h0, busy_of(0)}, 32'd0);

    // New request in the same cycle as done while the slot is full.
    pulse_rx(0, 16'h3444);
    pulse_rx(0, 16'h3555);
    wait_tx(0, 20, lat);
    check("sim first", {16'h0, tx_msg_of(0)}, 32'h0000_B444);
    tick();
    rx_vld[0] = 1'b1;
    rx_msg[0] = 16'h3666;
    tx_dne[0] = 1'b1;
    tick();
    rx_vld[0] = 1'b0;
    tx_dne[0] = 1'b0;
    wait_tx(0, 20, lat);
    check("sim pending", (lat < 0) ? 32'hDEAD : {16'h0, tx_msg_of(0)}, 32'h0000_B555);
    tick();
    pulse_dne(0);
    wait_tx(0, 20, lat);
    check("sim new", (lat < 0) ? 32'hDEAD : {16'h0, tx_msg_of(0)}, 32'h0000_B666);
    tick();
    pulse_dne(0);
    wait_idle(0, 10);
    check("sim ovf", {24'h0, ovf_of(0)}, 32'd1);

    // Done never arrives on the short-timeout instance.
    pulse_rx(1, 16'h3777);
    wait_tx(1, 20, lat);
    check("tmo reply", {16'h0, tx_msg_of(1)}, 32'h0000_B777);
    tick();
    check("tmo before", {31'h0, tmo_of(1)}, 32'd0);
    n = 0;
    while (busy_of(1) && n < 100) begin
      tick();
      n++;
    end
    check("tmo cycles", n, 16);
    check("tmo err", {31'h0, tmo_of(1)}, 32'd1);
    check("tmo msg kept", {16'h0, tx_msg_of(1)}, 32'h0000_B777);
    send_req(1, 16'h30AA, 16'hB0AA, "tmo ping");
    check("tmo sticky", {31'h0, tmo_of(1)}, 32'd1);

    // Reset while the reply is in its turnaround gap.
    send_req(0, 16'h19C3, 16'h99C3, "pre rst wr");
    pulse_rx(0, 16'h2900);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_tx(0, 20, seen);
    check("rst abort tx", seen, 0);
    check("rst abort busy", {31'h0, busy_of(0)}, 32'd0);
    check("rst abort msg", {16'h0, tx_msg_of(0)}, 32'd0);
    check("rst abort ovf", {24'h0, ovf_of(0)}, 32'd0);
    check("rst abort tmo", {31'h0, tmo_of(1)}, 32'd0);
    send_req(0, 16'h2900, 16'hA900, "rst reg");

    // Flood while busy: one buffered, 257 dropped, counter saturates.
    pulse_rx(0, 16'h3001);
    for (int i = 0; i < 258; i++) begin
      rx_vld[0] = 1'b1;
      rx_msg[0] = {8'h3E, 8'(i)};
      tick();
    end
    rx_vld[0] = 1'b0;
    check("ovf sat", {24'h0, ovf_of(0)}, 32'h0000_00FF);
    check("ovf first msg", {16'h0, tx_msg_of(0)}, 32'h0000_B001);
    pulse_dne(0);
    wait_tx(0, 20, lat);
    check("ovf pending", (lat < 0) ? 32'hDEAD : {16'h0, tx_msg_of(0)}, 32'h0000_BE00);
    tick();
    pulse_dne(0);
    wait_idle(0, 10);
    check("ovf idle", {31'h0, busy_of(0)}, 32'd0);
    check("ovf held", {24'h0, ovf_of(0)}, 32'h0000_00FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
